bt656_rx: RTL and testbench

BT656_RX -- requirements
Module: bt656_rx

---
 rtl/bt656_pkg.sv | 28 ++
 rtl/bt656_xy_decode.sv | 48 ++++
 rtl/bt656_rx.sv | 219 +++++++++++++++++++++
 tb/tb_bt656_rx.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bt656_pkg.sv
// bt656_pkg: shared definitions for the BT.656 receiver.
// Holds the preamble FSM encoding, the XY protection-bit function
// and the byte-position constants used on o_ByteSel.
package bt656_pkg;

  typedef enum logic [2:0] {
    PRE_HUNT   = 3'd0,
    PRE_FF     = 3'd1,
    PRE_Z1     = 3'd2,
    PRE_Z2     = 3'd3,
    PRE_XY     = 3'd4,
    PRE_ACTIVE = 3'd5
  } pre_state_t;

  localparam logic [7:0] BYTE_FF = 8'hFF;
  localparam logic [7:0] BYTE_00 = 8'h00;

  localparam logic [1:0] SEL_CB = 2'd0;
  localparam logic [1:0] SEL_Y0 = 2'd1;
  localparam logic [1:0] SEL_CR = 2'd2;
  localparam logic [1:0] SEL_Y1 = 2'd3;

  // Protection bits {P3,P2,P1,P0} carried in XY[3:0] for a given F/V/H.
  function automatic logic [3:0] xy_parity(input logic f, input logic v, input logic h);
    return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

endpackage

// File: rtl/bt656_xy_decode.sv
// bt656_xy_decode: combinational check of a BT.656 XY timing byte.
// Build macro BT656_RX_HAMMING_CORRECT_EN enables single-bit correction
// of XY[6:0]; without it any protection mismatch marks the code invalid.
// A cleared XY[7] always marks the code invalid.
module bt656_xy_decode
  import bt656_pkg::*;
(
  input  logic [7:0] xy,
  output logic       f,
  output logic       v,
  output logic       h,
  output logic       valid
);

  logic [3:0] syndrome;

  // Syndrome: received protection bits against those implied by the received F/V/H.
  always_comb begin
    syndrome = xy[3:0] ^ xy_parity(xy[6], xy[5], xy[4]);
  end

`ifdef BT656_RX_HAMMING_CORRECT_EN
  // Weight-1 syndromes are a flipped protection bit, weight-3 ones name the flipped
  // F/V/H bit, and any other non-zero pattern is a multi-bit error.
  always_comb begin
    f     = xy[6];
    v     = xy[5];
    h     = xy[4];
    valid = xy[7];
    case (syndrome)
      4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001: valid = xy[7];
      4'b0111: f = ~xy[6];
      4'b1011: v = ~xy[5];
      4'b1101: h = ~xy[4];
      default: valid = 1'b0;
    endcase
  end
`else
  // Without correction a code is only usable when every protection bit matches.
  always_comb begin
    f     = xy[6];
    v     = xy[5];
    h     = xy[4];
    valid = xy[7] && (syndrome == 4'b0000);
  end
`endif

endmodule

// File: rtl/bt656_rx.sv
// bt656_rx: BT.656 byte-stream receiver.
// Finds FF 00 00 XY timing codes, extracts F/V/H, forwards active-video bytes
// with their Cb/Y/Cr/Y position, counts lines per field, tracks lock and
// flags bad codes and wrong active-line lengths.
// Build macro BT656_RX_HAMMING_CORRECT_EN turns on single-bit XY correction.
module bt656_rx
  import bt656_pkg::*;
#(
  parameter int HACT_PIXELS = 1440,
  parameter int LOCK_CODES  = 2
) (
  input  logic        i_SysClock,
  input  logic        i_Reset,
  input  logic        i_DataValid,
  input  logic [7:0]  i_Data,
  output logic [7:0]  o_ActiveData,
  output logic        o_ActiveValid,
  output logic [1:0]  o_ByteSel,
  output logic        o_Fsignal,
  output logic        o_Vsignal,
  output logic        o_Hsignal,
  output logic        o_FieldStart,
  output logic [10:0] o_LineCount,
  output logic        o_Locked,
  output logic        o_ParityErr,
  output logic        o_LenErr
);

  localparam logic [11:0] HACT_LEN = 12'(HACT_PIXELS);
  localparam logic [7:0]  LOCK_LEN = 8'(LOCK_CODES);
  localparam logic [11:0] CNT_MAX  = 12'hFFF;

  pre_state_t  state;
  pre_state_t  state_next;

  logic        dec_f;
  logic        dec_v;
  logic        dec_h;
  logic        dec_valid;

  logic        code_seen;
  logic        code_ok;
  logic        code_bad;
  logic        sav_start;
  logic        eav_seen;
  logic        active_byte;
  logic        run_end;

  logic [11:0] byte_cnt;
  logic [1:0]  sel_cnt;
  logic        run_pending;
  logic [7:0]  lock_cnt;
  logic [7:0]  lock_inc;

  bt656_xy_decode u_xy_decode (
    .xy    (i_Data),
    .f     (dec_f),
    .v     (dec_v),
    .h     (dec_h),
    .valid (dec_valid)
  );

  // State register for preamble detection and the active-video run.
  always_ff @(posedge i_SysClock) begin
    if (i_Reset) begin
      state <= PRE_HUNT;
    end else begin
      state <= state_next;
    end
  end

  // Next state: advance only on accepted bytes; a stray 0xFF always restarts the preamble.
  always_comb begin
    state_next = state;
    if (i_DataValid) begin
      case (state)
        PRE_HUNT, PRE_XY: begin
          state_next = (i_Data == BYTE_FF) ? PRE_FF : PRE_HUNT;
        end
        PRE_FF: begin
          if (i_Data == BYTE_00) begin
            state_next = PRE_Z1;
          end else if (i_Data == BYTE_FF) begin
            state_next = PRE_FF;
          end else begin
            state_next = PRE_HUNT;
          end
        end
        PRE_Z1: begin
          if (i_Data == BYTE_00) begin
            state_next = PRE_Z2;
          end else if (i_Data == BYTE_FF) begin
            state_next = PRE_FF;
          end else begin
            state_next = PRE_HUNT;
          end
        end
        PRE_Z2: begin
          if (!dec_valid) begin
            state_next = PRE_HUNT;
          end else if (!dec_h && !dec_v) begin
            state_next = PRE_ACTIVE;
          end else begin
            state_next = PRE_XY;
          end
        end
        PRE_ACTIVE: begin
          state_next = (i_Data == BYTE_FF) ? PRE_FF : PRE_ACTIVE;
        end
        default: begin
          state_next = PRE_HUNT;
        end
      endcase
    end
  end

  // Per-byte events derived from the current state and the accepted byte.
  always_comb begin
    code_seen   = i_DataValid && (state == PRE_Z2);
    code_ok     = code_seen && dec_valid;
    code_bad    = code_seen && !dec_valid;
    sav_start   = code_ok && !dec_h && !dec_v;
    eav_seen    = code_ok && dec_h;
    active_byte = i_DataValid && (state == PRE_ACTIVE) && (i_Data != BYTE_FF);
    run_end     = i_DataValid && (state == PRE_ACTIVE) && (i_Data == BYTE_FF);
    lock_inc    = (lock_cnt < LOCK_LEN) ? lock_cnt + 8'd1 : lock_cnt;
  end

  // Active byte forwarding, position tracking and saturating run length.
  always_ff @(posedge i_SysClock) begin
    if (i_Reset) begin
      o_ActiveData  <= 8'd0;
      o_ActiveValid <= 1'b0;
      o_ByteSel     <= SEL_CB;
      sel_cnt       <= SEL_CB;
      byte_cnt      <= 12'd0;
    end else begin
      o_ActiveValid <= 1'b0;
      if (sav_start) begin
        sel_cnt  <= SEL_CB;
        byte_cnt <= 12'd0;
      end
      if (active_byte) begin
        sel_cnt  <= sel_cnt + 2'd1;
        byte_cnt <= (byte_cnt == CNT_MAX) ? byte_cnt : byte_cnt + 12'd1;
        if (o_Locked) begin
          o_ActiveData  <= i_Data;
          o_ActiveValid <= 1'b1;
          o_ByteSel     <= sel_cnt;
        end
      end
    end
  end

  // Remember that an active run just ended so the following EAV can judge its length.
  always_ff @(posedge i_SysClock) begin
    if (i_Reset) begin
      run_pending <= 1'b0;
      o_LenErr    <= 1'b0;
    end else begin
      o_LenErr <= 1'b0;
      if (run_end) begin
        run_pending <= 1'b1;
      end
      if (code_seen || (i_DataValid && state_next == PRE_HUNT)) begin
        run_pending <= 1'b0;
      end
      if (eav_seen && run_pending && (byte_cnt != HACT_LEN)) begin
        o_LenErr <= 1'b1;
      end
    end
  end

  // Timing flags, field start detection and line counting from valid codes.
  always_ff @(posedge i_SysClock) begin
    if (i_Reset) begin
      o_Fsignal    <= 1'b0;
      o_Vsignal    <= 1'b1;
      o_Hsignal    <= 1'b1;
      o_FieldStart <= 1'b0;
      o_LineCount  <= 11'd0;
    end else begin
      o_FieldStart <= 1'b0;
      if (code_ok) begin
        o_Fsignal <= dec_f;
        o_Vsignal <= dec_v;
        o_Hsignal <= dec_h;
      end
      if (eav_seen) begin
        if (dec_f != o_Fsignal) begin
          o_FieldStart <= 1'b1;
          o_LineCount  <= 11'd0;
        end else begin
          o_LineCount  <= o_LineCount + 11'd1;
        end
      end
    end
  end

  // Lock tracking: count consecutive good codes, drop everything on a bad one.
  always_ff @(posedge i_SysClock) begin
    if (i_Reset) begin
      lock_cnt    <= 8'd0;
      o_Locked    <= 1'b0;
      o_ParityErr <= 1'b0;
    end else begin
      o_ParityErr <= 1'b0;
      if (code_bad) begin
        lock_cnt    <= 8'd0;
        o_Locked    <= 1'b0;
        o_ParityErr <= 1'b1;
      end else if (code_ok) begin
        lock_cnt <= lock_inc;
        o_Locked <= (lock_inc >= LOCK_LEN);
      end
    end
  end

endmodule

// File: tb/tb_bt656_rx.sv
// tb_bt656_rx: directed scenarios with random payload bytes for bt656_rx,
// compared each cycle against a byte-level reference of the BT.656 rules.
module tb_bt656_rx;

  localparam int HACT  = 1440;
  localparam int LOCKN = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        dv;
  logic [7:0]  din;
  logic [7:0]  active_data;
  logic        active_valid;
  logic [1:0]  byte_sel;
  logic        f_sig;
  logic        v_sig;
  logic        h_sig;
  logic        field_start;
  logic [10:0] line_count;
  logic        locked;
  logic        parity_err;
  logic        len_err;

  int compared   = 0;
  int mismatched = 0;

  logic        exp_av;
  logic [7:0]  exp_data;
  logic [1:0]  exp_sel;
  logic        exp_fs;
  logic        exp_pe;
  logic        exp_le;

  logic [7:0]  win[$];
  logic        m_active;
  logic        m_pending;
  int          m_run;
  int          m_streak;
  int          m_line;
  logic        m_f;
  logic        m_v;
  logic        m_h;

  int          av_count;
  int          le_count;
  int          fs_count;
  int          pe_count;
  logic [7:0]  cap[$];
  logic [7:0]  line_bytes[HACT];
  logic        toggle_mode;
  int          line0;
  int          diffs;

  always #5 clk = ~clk;

  bt656_rx #(.HACT_PIXELS(HACT), .LOCK_CODES(LOCKN)) dut (
    .i_SysClock    (clk),
    .i_Reset       (rst),
    .i_DataValid   (dv),
    .i_Data        (din),
    .o_ActiveData  (active_data),
    .o_ActiveValid (active_valid),
    .o_ByteSel     (byte_sel),
    .o_Fsignal     (f_sig),
    .o_Vsignal     (v_sig),
    .o_Hsignal     (h_sig),
    .o_FieldStart  (field_start),
    .o_LineCount   (line_count),
    .o_Locked      (locked),
    .o_ParityErr   (parity_err),
    .o_LenErr      (len_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // The legal XY byte for a given F/V/H triple.
  function automatic logic [7:0] code_for(input int fvh);
    logic f;
    logic v;
    logic h;
    f = fvh[2];
    v = fvh[1];
    h = fvh[0];
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  // Search the eight legal codes for an exact (or, with correction, one-bit-off) match.
  task automatic model_decode(input logic [7:0] b, output logic ok, output logic [2:0] fvh);
    logic [7:0] c;
    ok  = 1'b0;
    fvh = 3'd0;
    if (b[7]) begin
      for (int i = 0; i < 8; i++) begin
        c = code_for(i);
        if (c[6:0] == b[6:0]) begin
          ok  = 1'b1;
          fvh = i[2:0];
        end
      end
`ifdef BT656_RX_HAMMING_CORRECT_EN
      if (!ok) begin
        for (int i = 0; i < 8; i++) begin
          c = code_for(i);
          if ($countones(c[6:0] ^ b[6:0]) == 1) begin
            ok  = 1'b1;
            fvh = i[2:0];
          end
        end
      end
`endif
    end
  endtask

  // True while the recent bytes could still be the start of FF 00 00.
  function automatic logic chain_alive();
    int n;
    n = win.size();
    if (n >= 1 && win[n-1] == 8'hFF) return 1'b1;
    if (n >= 2 && win[n-2] == 8'hFF && win[n-1] == 8'h00) return 1'b1;
    if (n >= 3 && win[n-3] == 8'hFF && win[n-2] == 8'h00 && win[n-1] == 8'h00) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear_pulses();
    exp_av = 1'b0;
    exp_fs = 1'b0;
    exp_pe = 1'b0;
    exp_le = 1'b0;
  endtask

  task automatic model_reset();
    model_clear_pulses();
    exp_data  = 8'd0;
    exp_sel   = 2'd0;
    win.delete();
    m_active  = 1'b0;
    m_pending = 1'b0;
    m_run     = 0;
    m_streak  = 0;
    m_line    = 0;
    m_f       = 1'b0;
    m_v       = 1'b1;
    m_h       = 1'b1;
  endtask

  task automatic model_step(input logic [7:0] b);
    logic       ok;
    logic [2:0] fvh;
    int         run_sat;
    model_clear_pulses();
    if (m_active) begin
      if (b == 8'hFF) begin
        m_active  = 1'b0;
        m_pending = 1'b1;
        win.delete();
        win.push_back(b);
      end else begin
        if (m_streak >= LOCKN) begin
          exp_av   = 1'b1;
          exp_data = b;
          exp_sel  = 2'(m_run % 4);
        end
        m_run++;
      end
    end else if (win.size() == 3 && win[0] == 8'hFF && win[1] == 8'h00 && win[2] == 8'h00) begin
      model_decode(b, ok, fvh);
      win.delete();
      if (!ok) begin
        exp_pe   = 1'b1;
        m_streak = 0;
      end else begin
        m_streak++;
        if (fvh[0]) begin
          if (fvh[2] != m_f) begin
            exp_fs = 1'b1;
            m_line = 0;
          end else begin
            m_line = (m_line + 1) % 2048;
          end
          run_sat = (m_run > 4095) ? 4095 : m_run;
          if (m_pending && run_sat != HACT) exp_le = 1'b1;
        end
        m_f = fvh[2];
        m_v = fvh[1];
        m_h = fvh[0];
        if (!fvh[1] && !fvh[0]) begin
          m_active = 1'b1;
          m_run    = 0;
        end
      end
      m_pending = 1'b0;
    end else begin
      win.push_back(b);
      if (win.size() > 3) void'(win.pop_front());
      if (!chain_alive()) m_pending = 1'b0;
    end
  endtask

  task automatic check_cycle(input logic r);
    checkOutput("active_valid", active_valid, exp_av);
    if (exp_av) begin
      checkOutput("active_data", active_data, exp_data);
      checkOutput("byte_sel", byte_sel, exp_sel);
    end
    if (r) begin
      checkOutput("reset_data", active_data, 8'd0);
      checkOutput("reset_sel", byte_sel, 2'd0);
    end
    checkOutput("field_start", field_start, exp_fs);
    checkOutput("parity_err", parity_err, exp_pe);
    checkOutput("len_err", len_err, exp_le);
    checkOutput("locked", locked, (m_streak >= LOCKN));
    checkOutput("line_count", line_count, m_line);
    checkOutput("fvh", {f_sig, v_sig, h_sig}, {m_f, m_v, m_h});
    if (active_valid) begin
      av_count++;
      cap.push_back(active_data);
    end
    if (len_err) le_count++;
    if (field_start) fs_count++;
    if (parity_err) pe_count++;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic v, input logic r);
    @(negedge clk);
    din = b;
    dv  = v;
    rst = r;
    @(posedge clk);
    if (r) model_reset();
    else if (v) model_step(b);
    else model_clear_pulses();
    #1;
    check_cycle(r);
  endtask

  task automatic send_byte(input logic [7:0] b);
    if (toggle_mode) applyStimulus(8'($urandom), 1'b0, 1'b0);
    applyStimulus(b, 1'b1, 1'b0);
  endtask

  task automatic send_code(input logic [7:0] xy);
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(xy);
  endtask

  task automatic send_blank(input int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom_range(1, 254)));
  endtask

  task automatic clear_counts();
    av_count = 0;
    le_count = 0;
    fs_count = 0;
    pe_count = 0;
    cap.delete();
  endtask

  task automatic compare_capture(input string tag);
    diffs = 0;
    for (int i = 0; i < HACT; i++) begin
      if (i >= cap.size() || cap[i] !== line_bytes[i]) diffs++;
    end
    checkOutput(tag, diffs, 0);
  endtask

  initial begin
    rst = 1'b1;
    dv = 1'b0;
    din = 8'd0;
    toggle_mode = 1'b0;
    model_reset();
    clear_counts();

    repeat (3) applyStimulus(8'h00, 1'b0, 1'b1);
    checkOutput("reset_vh", {v_sig, h_sig}, 2'b11);

    send_blank(6);
    send_code(8'h9D);
    send_blank(10);
    send_code(8'h9D);
    send_blank(4);
    checkOutput("lock_acquired", locked, 1'b1);

    for (int i = 0; i < HACT; i++) line_bytes[i] = 8'($urandom_range(1, 254));

    clear_counts();
    send_code(8'h80);
    for (int i = 0; i < HACT; i++) send_byte(line_bytes[i]);
    send_code(8'h9D);
    send_blank(4);
    checkOutput("full_line_av_count", av_count, HACT);
    checkOutput("full_line_len_err", le_count, 0);
    compare_capture("full_line_bytes");

    clear_counts();
    send_code(8'h80);
    send_blank(1000);
    send_code(8'h9D);
    send_blank(4);
    checkOutput("short_line_len_err", le_count, 1);

    clear_counts();
    send_code(8'h9D);
    send_blank(3);
    send_code(8'hDA);
    send_blank(3);
    checkOutput("field_flip_pulses", fs_count, 1);
    checkOutput("field_flip_line", line_count, 0);

    clear_counts();
    send_code(8'h9C);
    send_blank(3);
`ifdef BT656_RX_HAMMING_CORRECT_EN
    checkOutput("xy9c_parity_err", pe_count, 0);
    checkOutput("xy9c_fvh", {f_sig, v_sig, h_sig}, 3'b001);
`else
    checkOutput("xy9c_parity_err", pe_count, 1);
    checkOutput("xy9c_locked", locked, 1'b0);
`endif

    send_code(8'h9D);
    send_blank(2);
    send_code(8'h9D);
    send_blank(2);
    checkOutput("relock", locked, 1'b1);

    clear_counts();
    toggle_mode = 1'b1;
    send_code(8'h80);
    for (int i = 0; i < HACT; i++) send_byte(line_bytes[i]);
    send_code(8'h9D);
    send_blank(2);
    toggle_mode = 1'b0;
    checkOutput("toggle_av_count", av_count, HACT);
    checkOutput("toggle_len_err", le_count, 0);
    compare_capture("toggle_line_bytes");

    line0 = m_line;
    for (int i = 0; i < 2050; i++) send_code(8'h9D);
    checkOutput("line_wrap", line_count, (line0 + 2050) % 2048);

    clear_counts();
    send_code(8'h80);
    send_blank(700);
    applyStimulus(8'h55, 1'b1, 1'b1);
    checkOutput("midline_reset_av", active_valid, 1'b0);
    checkOutput("midline_reset_locked", locked, 1'b0);
    send_blank(3);
    send_code(8'h9D);
    send_blank(3);
    checkOutput("midline_reset_len_err", le_count, 0);

    applyStimulus(8'h00, 1'b0, 1'b1);
    clear_counts();
    send_code(8'h80);
    send_blank(8);
    send_code(8'h9D);
    send_blank(2);
    checkOutput("unlocked_no_data", av_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
